// File: rtl/div_dispatch.sv
// -----------------------------------------------------------------------------
// div_dispatch
//
// Queues divide requests in a small FIFO and feeds them one at a time to an
// external multi-cycle divider. Each result is held on the output until the
// consumer accepts it, and results come back in request order.
//
// A zero divisor is answered locally without starting the divider: quotient
// all ones, remainder = low M bits of the dividend, out_dbz set. A divider
// that does not answer within TIMEOUT cycles is abandoned: quotient and
// remainder read 0 and out_tmo is set.
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   in_valid / in_ready              request handshake (in_ready = !full)
//   in_dividend, in_divisor [N]      request operands
//   div_start                        one-cycle start pulse to the divider
//   div_dividend, div_divisor [N]    operands, stable from div_start to capture
//   div_quotient [N], div_remainder [M], div_done   divider response
//   out_valid / out_ready            result handshake
//   out_quotient [N], out_remainder [M]             result data
//   out_dbz, out_tmo                 divide-by-zero / timeout flags
//                                    (0 whenever out_valid is 0)
// -----------------------------------------------------------------------------
module div_dispatch #(
  parameter int N       = 64,
  parameter int M       = 64,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_dividend,
  input  logic [N-1:0] in_divisor,
  output logic         div_start,
  output logic [N-1:0] div_dividend,
  output logic [N-1:0] div_divisor,
  input  logic [N-1:0] div_quotient,
  input  logic [M-1:0] div_remainder,
  input  logic         div_done,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_quotient,
  output logic [M-1:0] out_remainder,
  output logic         out_dbz,
  output logic         out_tmo
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);

  // ---------------------------------------------------------------------------
  // Request FIFO: pointers carry one extra wrap bit so full and empty can be
  // told apart when the indices match.
  // ---------------------------------------------------------------------------
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [N-1:0] mem_dividend [DEPTH];
  logic [N-1:0] mem_divisor  [DEPTH];
  logic         full, empty, push, pop;
  logic [N-1:0] head_dividend, head_divisor;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A full FIFO refuses a push even when a pop happens on the same edge.
  assign in_ready = !full;
  assign push     = in_valid && !full;

  assign head_dividend = mem_dividend[rd_ptr_q[AW-1:0]];
  assign head_divisor  = mem_divisor[rd_ptr_q[AW-1:0]];

  assign wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
  assign rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

  // NOTE: storage arrays are not reset; the pointers alone decide which
  // entries are live, so clearing the data would add reset fan-out for nothing.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_dividend[wr_ptr_q[AW-1:0]] <= in_dividend;
      mem_divisor[wr_ptr_q[AW-1:0]]  <= in_divisor;
    end
  end

  // ---------------------------------------------------------------------------
  // Dispatch FSM and result registers
  // ---------------------------------------------------------------------------
  logic [1:0]   state_q, state_d;
  logic [N-1:0] opa_q, opa_d;
  logic [N-1:0] opb_q, opb_d;
  logic [N-1:0] quot_q, quot_d;
  logic [M-1:0] rem_q, rem_d;
  logic         dbz_q, dbz_d;
  logic         tmo_q, tmo_d;
  logic [7:0]   cnt_q, cnt_d;

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    tmo_d   = tmo_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!empty) pop = 1'b1;
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A response arriving on the last counted cycle still wins.
        if (div_done) begin
          quot_d  = div_quotient;
          rem_d   = div_remainder;
          state_d = S_HOLD;
        end else if (cnt_q == TMO_LAST) begin
          quot_d  = '0;
          rem_d   = '0;
          tmo_d   = 1'b1;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          if (!empty) begin
            pop = 1'b1;
          end else begin
            dbz_d   = 1'b0;
            tmo_d   = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Loading the head is shared by IDLE and the back-to-back path out of HOLD.
    if (pop) begin
      opa_d = head_dividend;
      opb_d = head_divisor;
      tmo_d = 1'b0;
      if (head_divisor == '0) begin
        dbz_d   = 1'b1;
        quot_d  = '1;
        rem_d   = M'(head_dividend);
        state_d = S_HOLD;
      end else begin
        dbz_d   = 1'b0;
        state_d = S_ISSUE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      state_q  <= S_IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      dbz_q    <= 1'b0;
      tmo_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      dbz_q    <= dbz_d;
      tmo_q    <= tmo_d;
      cnt_q    <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign div_start     = (state_q == S_ISSUE);
  assign div_dividend  = opa_q;
  assign div_divisor   = opb_q;
  assign out_valid     = (state_q == S_HOLD);
  assign out_quotient  = quot_q;
  assign out_remainder = rem_q;
  assign out_dbz       = out_valid && dbz_q;
  assign out_tmo       = out_valid && tmo_q;

endmodule

// File: tb/tb_div_dispatch.sv
// -----------------------------------------------------------------------------
// tb_div_dispatch
//
// Drives div_dispatch (TIMEOUT=8) with directed and random requests. A small
// divider model answers div_start after a random delay (or never), and a
// scoreboard holds the result expected for every accepted request, computed
// from the operands with plain / and %.
// -----------------------------------------------------------------------------
module tb_div_dispatch;
  localparam int N       = 64;
  localparam int M       = 64;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_dividend = '0;
  logic [N-1:0] in_divisor = '0;
  logic         div_start;
  logic [N-1:0] div_dividend, div_divisor;
  logic [N-1:0] div_quotient = '0;
  logic [M-1:0] div_remainder = '0;
  logic         div_done = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [N-1:0] out_quotient;
  logic [M-1:0] out_remainder;
  logic         out_dbz, out_tmo;

  div_dispatch #(.N(N), .M(M), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_dividend  (in_dividend),
    .in_divisor   (in_divisor),
    .div_start    (div_start),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_quotient (div_quotient),
    .div_remainder(div_remainder),
    .div_done     (div_done),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_quotient (out_quotient),
    .out_remainder(out_remainder),
    .out_dbz      (out_dbz),
    .out_tmo      (out_tmo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] q;
    logic [M-1:0] r;
    logic         dbz;
    logic         tmo;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   start_count = 0;
  bit   no_respond = 1'b0;
  bit   spurious = 1'b0;
  bit   rand_ready = 1'b0;
  bit   ready_hold = 1'b1;

  // Expected result of one request, from the arithmetic rules alone.
  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                 input bit nr);
    exp_t e;
    if (b == '0)   e = '{q: '1, r: a, dbz: 1'b1, tmo: 1'b0};
    else if (nr)   e = '{q: '0, r: '0, dbz: 1'b0, tmo: 1'b1};
    else           e = '{q: a / b, r: a % b, dbz: 1'b0, tmo: 1'b0};
    return e;
  endfunction

  // out_ready driver: fixed level or random per cycle.
  always @(posedge clk) begin
    #1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_hold;
  end

  // Divider model: answers 1..6 cycles after div_start using the operands it
  // sees at answer time, or never when no_respond is set.
  bit busy = 1'b0;
  int lat = 0;
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      busy     = 1'b0;
      div_done = 1'b0;
    end else begin
      div_done = spurious;
      if (spurious) begin
        div_quotient  = {$urandom, $urandom};
        div_remainder = {$urandom, $urandom};
      end
      if (busy) begin
        if (lat == 0) begin
          div_done      = 1'b1;
          div_quotient  = (div_divisor != '0) ? div_dividend / div_divisor : '1;
          div_remainder = (div_divisor != '0) ? div_dividend % div_divisor : '0;
          busy          = 1'b0;
        end else begin
          lat--;
        end
      end
      if (div_start) begin
        start_count++;
        busy = !no_respond;
        lat  = $urandom_range(0, 5);
      end
    end
  end

  // Scoreboard: every accepted result is matched against the oldest request;
  // flags must be low whenever no result is offered.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_result: got q=%h r=%h dbz=%b tmo=%b, expected none",
                   out_quotient, out_remainder, out_dbz, out_tmo);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if ({out_quotient, out_remainder, out_dbz, out_tmo} !== {e.q, e.r, e.dbz, e.tmo}) begin
            n_err++;
            $display("FAIL result: got q=%h r=%h dbz=%b tmo=%b, expected q=%h r=%h dbz=%b tmo=%b",
                     out_quotient, out_remainder, out_dbz, out_tmo, e.q, e.r, e.dbz, e.tmo);
          end
        end
      end
      if (!out_valid) begin
        n_cmp++;
        if ({out_dbz, out_tmo} !== 2'b00) begin
          n_err++;
          $display("FAIL flags_idle: got dbz=%b tmo=%b, expected 0 0", out_dbz, out_tmo);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (entered and left at posedge+1)
  // ---------------------------------------------------------------------------
  task automatic push(input logic [N-1:0] a, input logic [N-1:0] b, output int waited);
    waited      = 0;
    in_valid    = 1'b1;
    in_dividend = a;
    in_divisor  = b;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 300) begin
        n_cmp++;
        n_err++;
        $display("FAIL push_timeout: got in_ready=0 for %0d cycles, expected acceptance", waited);
        break;
      end
    end
    if (in_ready) exp_q.push_back(model(a, b, no_respond));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int t = 0;
    while (exp_q.size() != 0 || out_valid) begin
      @(negedge clk);
      t++;
      if (t > 2000) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s_drain: got %0d results outstanding, expected 0", tag, exp_q.size());
        exp_q.delete();
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({div_start, out_valid, out_dbz, out_tmo} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_ctrl: got start=%b valid=%b dbz=%b tmo=%b, expected all 0",
               div_start, out_valid, out_dbz, out_tmo);
    end
    n_cmp++;
    if ({out_quotient, out_remainder, div_dividend, div_divisor} !== '0) begin
      n_err++;
      $display("FAIL reset_data: got q=%h r=%h a=%h b=%h, expected all 0",
               out_quotient, out_remainder, div_dividend, div_divisor);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    int w;
    int s0 = start_count;
    push(64'h8765432187654321, 64'h654321, w);
    @(negedge clk);
    n_cmp++;
    if (div_start !== 1'b0) begin
      n_err++;
      $display("FAIL single_start_early: got %b, expected 0", div_start);
    end
    @(negedge clk);
    n_cmp++;
    if (div_start !== 1'b1) begin
      n_err++;
      $display("FAIL single_start: got %b, expected 1", div_start);
    end
    wait_drain("single");
    n_cmp++;
    if (start_count - s0 !== 1) begin
      n_err++;
      $display("FAIL single_start_count: got %0d, expected 1", start_count - s0);
    end
  endtask

  task automatic test_dbz();
    int w;
    int s0 = start_count;
    push(64'h1234567812345678, 64'h0, w);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL dbz_valid_early: got %b, expected 0", out_valid);
    end
    @(negedge clk);
    n_cmp++;
    if ({out_valid, out_dbz, out_quotient, out_remainder} !==
        {1'b1, 1'b1, 64'hFFFFFFFFFFFFFFFF, 64'h1234567812345678}) begin
      n_err++;
      $display("FAIL dbz_result: got valid=%b dbz=%b q=%h r=%h, expected 1 1 ffffffffffffffff 1234567812345678",
               out_valid, out_dbz, out_quotient, out_remainder);
    end
    wait_drain("dbz");
    n_cmp++;
    if (start_count - s0 !== 0) begin
      n_err++;
      $display("FAIL dbz_start_count: got %0d, expected 0", start_count - s0);
    end
  endtask

  task automatic test_full();
    int w;
    no_respond = 1'b1;
    push(64'd100, 64'd7, w);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < DEPTH; i++) begin
      push({$urandom, $urandom}, {32'h0, $urandom} | 64'h1, w);
      n_cmp++;
      if (w !== 0) begin
        n_err++;
        $display("FAIL full_early_block: push %0d waited %0d, expected 0", i, w);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL full_in_ready: got %b, expected 0", in_ready);
    end
    push(64'd55, 64'd5, w);
    n_cmp++;
    if (w < 1) begin
      n_err++;
      $display("FAIL full_fifth: waited %0d cycles, expected >= 1", w);
    end
    wait_drain("full");
    no_respond = 1'b0;
  endtask

  task automatic test_stall();
    int w;
    int t = 0;
    int s0;
    exp_t e;
    ready_hold = 1'b0;
    out_ready  = 1'b0;
    push({$urandom, $urandom}, {32'h0, $urandom} | 64'h3, w);
    push({$urandom, $urandom}, 64'd9, w);
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    s0 = start_count;
    e  = exp_q[0];
    for (int i = 0; i < 10; i++) begin
      spurious = (i == 3);
      @(negedge clk);
      n_cmp++;
      if ({out_valid, div_start, out_quotient, out_remainder, out_dbz, out_tmo} !==
          {1'b1, 1'b0, e.q, e.r, e.dbz, e.tmo}) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: got valid=%b start=%b q=%h r=%h, expected 1 0 %h %h",
                 i, out_valid, div_start, out_quotient, out_remainder, e.q, e.r);
      end
    end
    spurious = 1'b0;
    n_cmp++;
    if (start_count - s0 !== 0) begin
      n_err++;
      $display("FAIL stall_start_count: got %0d, expected 0", start_count - s0);
    end
    @(posedge clk);
    #1;
    ready_hold = 1'b1;
    out_ready  = 1'b1;
    wait_drain("stall");
  endtask

  task automatic test_timeout();
    int w;
    int t = 0;
    int n = 0;
    no_respond = 1'b1;
    push(64'hDEADBEEF, 64'd3, w);
    while (!div_start && t < 20) begin
      @(negedge clk);
      t++;
    end
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (n !== TIMEOUT + 1) begin
      n_err++;
      $display("FAIL timeout_latency: got %0d, expected %0d", n, TIMEOUT + 1);
    end
    n_cmp++;
    if ({out_tmo, out_dbz, out_quotient, out_remainder} !== {1'b1, 1'b0, 128'h0}) begin
      n_err++;
      $display("FAIL timeout_result: got tmo=%b dbz=%b q=%h r=%h, expected 1 0 0 0",
               out_tmo, out_dbz, out_quotient, out_remainder);
    end
    wait_drain("timeout");
    no_respond = 1'b0;
  endtask

  task automatic test_random();
    int w;
    logic [N-1:0] a, b;
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      a = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       b = N'($urandom_range(1, 15));
        default: b = {$urandom, $urandom} | 64'h1;
      endcase
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 6)) @(posedge clk);
        #1;
      end
      push(a, b, w);
    end
    wait_drain("random");
    rand_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int w;
    no_respond = 1'b1;
    push(64'd1000, 64'd10, w);
    push(64'd2000, 64'd20, w);
    push(64'd3000, 64'd0, w);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    n_cmp++;
    if ({out_valid, div_start, out_dbz, out_tmo, out_quotient, div_dividend} !== '0) begin
      n_err++;
      $display("FAIL midreset_outputs: got valid=%b start=%b q=%h a=%h, expected all 0",
               out_valid, div_start, out_quotient, div_dividend);
    end
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    no_respond = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({out_valid, div_start, in_ready} !== 3'b001) begin
        n_err++;
        $display("FAIL midreset_quiet[%0d]: got valid=%b start=%b in_ready=%b, expected 0 0 1",
                 i, out_valid, div_start, in_ready);
      end
    end
    @(posedge clk);
    #1;
    push(64'd777, 64'd7, w);
    wait_drain("midreset");
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_dbz();
    test_full();
    test_stall();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
